sqr6_tt_sweeper: RTL and testbench
==================================

Name: sqr6_tt_sweeper

Overview:
- Sequential harness that sits directly around one single-output sqr6 cone.
- Upstream role: drives all 64 input vectors onto x0..x5, one per cycle.
- Downstream role: consumes y0 after a fixed latency and assembles the 64-bit truth table.
- Compares the table against an expected constant, so D-reduced or optimised variants of a cone can be checked in simulation or on FPGA without a testbench-side model.

Parameters:
- LAT, 0, cycles from x-drive to valid y0 (0 = combinational cone, sampled the same cycle; N = cone with N register stages).
- EXP_TT, 64'h0, expected truth table; bit i = y0 for vector i.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; ignored unless in IDLE or DONE.
- x0..x5  output  1 each  vector bits to the cone; xk = idx[k].
- y0  input  1  cone output.
- busy  output  1  high during SWEEP and DRAIN.
- done  output  1  high in DONE until the next accepted start.
- match  output  1  tt == EXP_TT; valid only while done=1, else 0.
- tt  output  64  captured truth table.

Behaviour:
- Reset (async assert, sync deassert expected from the system):
  - state=IDLE, idx=0, x0..x5=0, tt=0.
  - busy=0, done=0, match=0.
  - Capture delay line cleared.
- States IDLE, SWEEP, DRAIN, DONE. All state and outputs are registered.
- IDLE/DONE with start=1:
  - next state SWEEP; idx=0, tt=0, done=0, match=0, busy=1.
  - idx is presented on x the cycle SWEEP is entered.
- SWEEP:
  - x=idx each cycle; idx increments by 1.
  - A delay line of LAT stages carries {valid, idx}; at its output, tt[idx_d] <= y0.
  - With LAT=0, y0 is sampled the same cycle the vector is on x.
  - When idx==63 has been driven: LAT==0 goes directly to DONE; otherwise to DRAIN.
  - idx wraps to 0 and x holds 0 after the last drive.
- DRAIN: stays exactly LAT cycles, capturing the remaining delayed samples, then goes to DONE.
- DONE: busy=0, done=1, match=(tt==EXP_TT). tt holds.
- Total latency, start-accept to done=1: 64+LAT+1 cycles.
- start during SWEEP/DRAIN: ignored; the sweep is not restarted.
- start in the same cycle as the DONE transition: ignored; it is accepted only once the state is DONE.
- rst_n low mid-sweep: immediate return to reset values; the partial tt is discarded.
- Only the delayed index is ever written, so each tt bit is written exactly once per sweep. No read-modify races.
- Sample rule: y0 is taken as-is; X/Z propagates into tt in simulation.

Optional Feature:
- Macro: SQR6_SWEEP_MISR_EN.
- Defined:
  - Adds output sig [15:0], a MISR with polynomial x^16+x^12+x^3+x+1.
  - Seed 16'hFFFF on sweep start.
  - On each captured sample: sig <= {sig[14:0],fb} ^ {15'b0,y0}, where fb = sig[15]^sig[11]^sig[2]^sig[0].
  - sig holds in DONE and resets to 16'hFFFF.
- Not defined: no sig port, no MISR logic; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 mid-sweep (idx≈20) -> next edge-free check shows busy=0, done=0, tt=0, x=0; state IDLE.
- LAT=0, cone y0=x0, EXP_TT=64'hAAAA_AAAA_AAAA_AAAA, start pulse:
  - done rises exactly 65 cycles after start accepted.
  - tt=64'hAAAA_AAAA_AAAA_AAAA, match=1.
- LAT=2, cone y0 = x5 registered twice, EXP_TT=64'hFFFF_FFFF_0000_0000:
  - done at 67 cycles.
  - tt=64'hFFFF_FFFF_0000_0000, match=1.
  - busy high for 66 cycles.
- Mismatch: cone y0=0, EXP_TT=64'h1 -> tt=0, match=0, done=1.
- start held high through the whole sweep -> exactly one sweep runs, with no restart during SWEEP/DRAIN; a new sweep starts only from DONE (tt is cleared then refilled with the same value).
- With SQR6_SWEEP_MISR_EN, y0=0 throughout -> sig equals the 64-step free-running LFSR value from 16'hFFFF (golden from the bench model); y0=x0 gives a different value from that zero-input run.

Source files
------------

// File: rtl/sqr6_tt_sweeper.sv
// Truth-table sweeper for one single-output sqr6 cone: drives 64 vectors, captures y0.
// Optional SQR6_SWEEP_MISR_EN adds a 16-bit MISR signature output `sig`.
module sqr6_tt_sweeper #(
    parameter int          LAT    = 0,
    parameter logic [63:0] EXP_TT = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        x0,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    output logic        x4,
    output logic        x5,
    input  logic        y0,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic [63:0] tt
`ifdef SQR6_SWEEP_MISR_EN
    ,
    output logic [15:0] sig
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [15:0] DLAST = (LAT > 0) ? 16'(LAT - 1) : 16'd0;

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [63:0] tt_q, tt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
    logic        accept;
    logic        cap_v;
    logic [5:0]  cap_idx;

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    // Capture point: the vector index that y0 belongs to this cycle
    generate
        if (LAT == 0) begin : g_nolat
            assign cap_v   = (state_q == S_SWEEP);
            assign cap_idx = idx_q;
        end else begin : g_lat
            logic [LAT-1:0] dv_q, dv_d;
            logic [5:0]     di_q [LAT];
            logic [5:0]     di_d [LAT];

            always_comb begin
                dv_d[0] = (state_q == S_SWEEP);
                di_d[0] = idx_q;
                for (int j = 1; j < LAT; j++) begin
                    dv_d[j] = dv_q[j-1];
                    di_d[j] = di_q[j-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dv_q <= '0;
                    for (int j = 0; j < LAT; j++) begin
                        di_q[j] <= '0;
                    end
                end else begin
                    dv_q <= dv_d;
                    for (int j = 0; j < LAT; j++) begin
                        di_q[j] <= di_d[j];
                    end
                end
            end

            assign cap_v   = dv_q[LAT-1];
            assign cap_idx = di_q[LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = S_SWEEP;
            end
            S_SWEEP: begin
                if (idx_q == 6'd63) state_d = (LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_q == DLAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_d == S_SWEEP) || (state_d == S_DRAIN);
        done_d  = (state_d == S_DONE);
        match_d = (state_d == S_DONE) && (tt_d == EXP_TT);
    end

    always_comb begin
        idx_d = idx_q;
        cnt_d = '0;
        tt_d  = tt_q;
        if (accept) begin
            idx_d = '0;
            tt_d  = '0;
        end else begin
            if (state_q == S_SWEEP) idx_d = idx_q + 6'd1;
            if (state_q == S_DRAIN) cnt_d = cnt_q + 16'd1;
            if (cap_v) tt_d[cap_idx] = y0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

`ifdef SQR6_SWEEP_MISR_EN
    logic [15:0] sig_q, sig_d;
    logic        fb;

    assign fb = sig_q[15] ^ sig_q[11] ^ sig_q[2] ^ sig_q[0];

    always_comb begin
        sig_d = sig_q;
        if (accept) begin
            sig_d = 16'hFFFF;
        end else if (cap_v) begin
            sig_d = {sig_q[14:0], fb} ^ {15'b0, y0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 16'hFFFF;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`endif

    assign x0    = idx_q[0];
    assign x1    = idx_q[1];
    assign x2    = idx_q[2];
    assign x3    = idx_q[3];
    assign x4    = idx_q[4];
    assign x5    = idx_q[5];
    assign busy  = busy_q;
    assign done  = done_q;
    assign match = match_q;
    assign tt    = tt_q;

endmodule

// File: tb/tb_sqr6_tt_sweeper.sv
// Bench for sqr6_tt_sweeper: three instances (LAT 0/2/0) around table-defined cones.
// Cone y0 = fn[x]; expected tt is the cone's own function table.
module tb_sqr6_tt_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_r [3];
    logic [63:0] fn [3];
    wire  [5:0]  xv_w [3];
    wire         busy_w [3];
    wire         done_w [3];
    wire         match_w [3];
    wire  [63:0] tt_w [3];
`ifdef SQR6_SWEEP_MISR_EN
    wire  [15:0] sig_w [3];
`endif

    int n_chk = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 1) ? 2 : 0;
        localparam logic [63:0] E = (g == 0) ? 64'hAAAA_AAAA_AAAA_AAAA :
                                    (g == 1) ? 64'hFFFF_FFFF_0000_0000 : 64'h1;
        wire [5:0] x;
        wire       yc;

        if (L == 0) begin : g_comb
            assign yc = fn[g][x];
        end else begin : g_reg
            logic r1 = 1'b0;
            logic r2 = 1'b0;
            always @(posedge clk) begin
                r1 <= fn[g][x];
                r2 <= r1;
            end
            assign yc = r2;
        end

        assign xv_w[g] = x;

        sqr6_tt_sweeper #(.LAT(L), .EXP_TT(E)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_r[g]),
            .x0    (x[0]),
            .x1    (x[1]),
            .x2    (x[2]),
            .x3    (x[3]),
            .x4    (x[4]),
            .x5    (x[5]),
            .y0    (yc),
            .busy  (busy_w[g]),
            .done  (done_w[g]),
            .match (match_w[g]),
            .tt    (tt_w[g])
`ifdef SQR6_SWEEP_MISR_EN
            ,
            .sig   (sig_w[g])
`endif
        );
    end

    function automatic int lat_of(input int s);
        return (s == 1) ? 2 : 0;
    endfunction

    function automatic logic [63:0] exp_of(input int s);
        case (s)
            0:       return 64'hAAAA_AAAA_AAAA_AAAA;
            1:       return 64'hFFFF_FFFF_0000_0000;
            default: return 64'h1;
        endcase
    endfunction

    // Signature of the 64 samples taken in vector order from seed FFFF
    function automatic logic [15:0] misr_of(input logic [63:0] f);
        logic [15:0] s;
        logic        fb;
        s = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            fb = s[15] ^ s[11] ^ s[2] ^ s[0];
            s = {s[14:0], fb} ^ {15'b0, f[i]};
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic sweep(input int s, input logic [63:0] f, input logic m, input bit hold);
        int  edges;
        int  busy_n;
        bit  got;
        fn[s] = f;
        @(negedge clk);
        start_r[s] = 1'b1;
        edges = 0;
        busy_n = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk);
            #1;
            if (!hold) start_r[s] = 1'b0;
            edges++;
            if (busy_w[s] === 1'b1) busy_n++;
            if (done_w[s] === 1'b1) got = 1'b1;
        end
        chk($sformatf("latency[%0d]", s), 64'(edges), 64'(65 + lat_of(s)));
        chk($sformatf("busy_cycles[%0d]", s), 64'(busy_n), 64'(64 + lat_of(s)));
        chk($sformatf("tt[%0d]", s), tt_w[s], f);
        chk($sformatf("match[%0d]", s), 64'(match_w[s]), 64'(m));
        chk($sformatf("busy_done[%0d]", s), 64'(busy_w[s]), 64'd0);
        chk($sformatf("x_done[%0d]", s), 64'(xv_w[s]), 64'd0);
`ifdef SQR6_SWEEP_MISR_EN
        chk($sformatf("sig[%0d]", s), 64'(sig_w[s]), 64'(misr_of(f)));
`endif
        if (hold) begin
            @(posedge clk);
            #1;
            chk($sformatf("restart_done[%0d]", s), 64'(done_w[s]), 64'd0);
            chk($sformatf("restart_busy[%0d]", s), 64'(busy_w[s]), 64'd1);
            chk($sformatf("restart_tt[%0d]", s), tt_w[s], 64'd0);
            chk($sformatf("restart_match[%0d]", s), 64'(match_w[s]), 64'd0);
            start_r[s] = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(posedge clk);
                #1;
                if (done_w[s] === 1'b1) got = 1'b1;
            end
            chk($sformatf("refill_done[%0d]", s), 64'(got), 64'd1);
            chk($sformatf("refill_tt[%0d]", s), tt_w[s], f);
        end
    endtask

    task automatic chk_reset(input string nm);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("%s_busy[%0d]", nm, s), 64'(busy_w[s]), 64'd0);
            chk($sformatf("%s_done[%0d]", nm, s), 64'(done_w[s]), 64'd0);
            chk($sformatf("%s_match[%0d]", nm, s), 64'(match_w[s]), 64'd0);
            chk($sformatf("%s_tt[%0d]", nm, s), tt_w[s], 64'd0);
            chk($sformatf("%s_x[%0d]", nm, s), 64'(xv_w[s]), 64'd0);
`ifdef SQR6_SWEEP_MISR_EN
            chk($sformatf("%s_sig[%0d]", nm, s), 64'(sig_w[s]), 64'hFFFF);
`endif
        end
    endtask

    typedef struct {
        int          s;
        logic [63:0] f;
        logic [63:0] tt;
        logic        m;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [63:0] rf;
        int          rs;
`ifdef SQR6_SWEEP_MISR_EN
        logic [15:0] sig_zero;
`endif
        tbl[0] = '{0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1};
        tbl[1] = '{1, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1};
        tbl[2] = '{2, 64'h0, 64'h0, 1'b0};
        tbl[3] = '{2, 64'h1, 64'h1, 1'b1};
        tbl[4] = '{1, 64'h0, 64'h0, 1'b0};
        tbl[5] = '{0, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b0};
        tbl[6] = '{1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0};

        for (int s = 0; s < 3; s++) begin
            start_r[s] = 1'b0;
            fn[s] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            sweep(tbl[i].s, tbl[i].f, tbl[i].m, 1'b0);
            chk($sformatf("tbl%0d_tt", i), tt_w[tbl[i].s], tbl[i].tt);
        end

        // start held through the sweep: one sweep, restarted only from DONE
        sweep(0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b1);
        sweep(1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);

        // Reset mid-sweep
        fn[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        fn[1] = 64'hFFFF_FFFF_0000_0000;
        @(negedge clk);
        start_r[0] = 1'b1;
        start_r[1] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        start_r[1] = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy", 64'(busy_w[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            rs = k % 3;
            rf = {$urandom, $urandom};
            if (k == 4) rf = exp_of(rs);
            sweep(rs, rf, (rf == exp_of(rs)), 1'b0);
        end

`ifdef SQR6_SWEEP_MISR_EN
        sweep(0, 64'h0, 1'b0, 1'b0);
        sig_zero = sig_w[0];
        sweep(0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0);
        n_chk++;
        if (sig_w[0] === sig_zero) begin
            n_fail++;
            $display("FAIL sig_differs: got %h want not %h", sig_w[0], sig_zero);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
